car_draw_control: RTL and testbench
===================================

Name: car_draw_control

Overview:
- Control FSM directly upstream of the drawing datapath.
- Sequences one-time background paint (black road, left/right green verges), then the car animation loop: draw car, wait, erase, update position, redraw.
- Watches the datapath's pixel counters (counterx/countery) and drives its strobes: draw_*, erase, update, plot, inc, done.
- plot doubles as the VGA adapter write enable.

Parameters:
- SCREEN_W, 160, background width in pixels
- SCREEN_H, 120, background height in pixels
- GRASS_W, 20, width of each green verge
- CAR_W, 8, car sprite width
- CAR_H, 12, car sprite height
- FRAME_CYCLES, 833333, clock cycles per 60 Hz frame at 50 MHz
- FRAMES_PER_MOVE, 4, frames waited between car moves

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  level; leaves IDLE when 1
- counterx  in  8  datapath column counter
- countery  in  8  datapath row counter
- draw_bg_black  out  1  datapath select: full-screen black
- draw_bg_green_left  out  1  datapath select: left verge
- draw_bg_green_right  out  1  datapath select: right verge
- draw_car  out  1  datapath select: car sprite
- erase  out  1  datapath select: car region in road colour
- update  out  1  one-cycle car position update strobe
- plot  out  1  pixel write enable / counter advance
- inc  out  1  end-of-row: datapath wraps counterx, increments countery
- done  out  1  last pixel of region: datapath clears both counters
- state  out  4  current state encoding, for debug/LEDs

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset (including mid-operation) forces IDLE on the next edge.
- Outputs are decoded from state, so all outputs are 0 in the cycle after reset.
- States, each with its region W x H:
  - IDLE (0)
  - BG_BLACK (1): SCREEN_W x SCREEN_H
  - BG_LEFT (2): GRASS_W x SCREEN_H
  - BG_RIGHT (3): GRASS_W x SCREEN_H
  - DRAW_CAR (4): CAR_W x CAR_H
  - WAIT (5)
  - ERASE (6): CAR_W x CAR_H
  - UPDATE (7)
- Transitions:
  - IDLE -> BG_BLACK when start=1; otherwise stay.
  - BG_BLACK -> BG_LEFT -> BG_RIGHT -> DRAW_CAR -> WAIT -> ERASE -> UPDATE -> DRAW_CAR (loop).
  - Draw states (1,2,3,4,6) advance on done.
  - WAIT advances when frame_cnt=FRAME_CYCLES-1 and move_cnt=FRAMES_PER_MOVE-1.
  - UPDATE lasts exactly 1 cycle.
- Draw-state outputs:
  - plot=1 every cycle in a draw state; exactly one draw_*/erase select is high, matching the state.
  - inc = plot & (counterx==W-1).
  - done = plot & (counterx==W-1) & (countery==H-1). inc is also high in that cycle; the datapath gives done priority.
  - inc and done are combinational from state and counters; no added latency.
  - Each region therefore takes exactly W*H cycles; the last pixel is plotted in the same cycle done is high.
- Non-draw states (IDLE, WAIT, UPDATE): plot=inc=done=0 and all selects are 0, except update=1 in UPDATE.
- start is ignored outside IDLE. The loop runs until reset; there is no pause.
- Frame timer:
  - frame_cnt is 20 bits; it wraps at FRAME_CYCLES-1 and increments move_cnt.
  - Both counters clear on every entry to WAIT and on reset.
  - WAIT lasts exactly FRAME_CYCLES*FRAMES_PER_MOVE cycles.
- Counter integrity: if counterx>=W or countery>=H in a draw state (datapath out of sync), done is never raised. This is a bench-checked illegal condition; no recovery logic is required.
- Width rules:
  - Comparisons are 8-bit unsigned; W-1 and H-1 are truncated to 8 bits.
  - Parameters must be in 1..255; FRAME_CYCLES must be in 1..2^20.

Test Plan:
Bench models the datapath counters. Parameters: SCREEN 4x3, GRASS_W=1, CAR 2x2, FRAME_CYCLES=3, FRAMES_PER_MOVE=2.
1. Reset held 2 cycles, start=0 for 10 cycles -> state=0 and all outputs 0 throughout.
2. start=1 for 1 cycle -> BG_BLACK: plot=1 for 12 cycles, inc high at counterx=3 (3 times), done only at (3,2). Then BG_LEFT and BG_RIGHT: 3 cycles each, inc every cycle. Then DRAW_CAR: 4 cycles.
3. After DRAW_CAR done -> WAIT for exactly 6 cycles with plot=0, then ERASE 4 cycles, then update=1 for exactly 1 cycle, then DRAW_CAR.
4. Let the loop run 3 iterations -> each iteration is 4+6+4+1=15 cycles, and the pattern repeats identically.
5. Assert reset in the 5th cycle of BG_BLACK and again mid-WAIT -> state=0 and all outputs 0 on the next edge. With start=1, the sequence restarts at BG_BLACK with the frame counters cleared.
6. Drive counterx=5 during DRAW_CAR -> done stays 0 and the state holds at 4.

Source files
------------

// File: rtl/car_draw_control.sv
// rtl/car_draw_control.sv - control FSM sequencing background paint and the car animation loop
module car_draw_control #(
  parameter int SCREEN_W        = 160,
  parameter int SCREEN_H        = 120,
  parameter int GRASS_W         = 20,
  parameter int CAR_W           = 8,
  parameter int CAR_H           = 12,
  parameter int FRAME_CYCLES    = 833333,
  parameter int FRAMES_PER_MOVE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] counterx,
  input  logic [7:0] countery,
  output logic       draw_bg_black,
  output logic       draw_bg_green_left,
  output logic       draw_bg_green_right,
  output logic       draw_car,
  output logic       erase,
  output logic       update,
  output logic       plot,
  output logic       inc,
  output logic       done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_BG_BLACK = 4'd1,
    S_BG_LEFT  = 4'd2,
    S_BG_RIGHT = 4'd3,
    S_DRAW_CAR = 4'd4,
    S_WAIT     = 4'd5,
    S_ERASE    = 4'd6,
    S_UPDATE   = 4'd7
  } state_t;

  // Region extents are compared as 8-bit unsigned values against the datapath counters.
  localparam logic [7:0]  SCREEN_W_LAST = 8'(SCREEN_W - 1);
  localparam logic [7:0]  SCREEN_H_LAST = 8'(SCREEN_H - 1);
  localparam logic [7:0]  GRASS_W_LAST  = 8'(GRASS_W - 1);
  localparam logic [7:0]  CAR_W_LAST    = 8'(CAR_W - 1);
  localparam logic [7:0]  CAR_H_LAST    = 8'(CAR_H - 1);
  localparam logic [19:0] FRAME_LAST    = 20'(FRAME_CYCLES - 1);
  localparam logic [7:0]  MOVE_LAST     = 8'(FRAMES_PER_MOVE - 1);

  state_t      cur_state;
  state_t      nxt_state;
  logic [19:0] frame_cnt;
  logic [7:0]  move_cnt;
  logic [7:0]  w_last;
  logic [7:0]  h_last;
  logic        wait_over;

  assign state     = cur_state;
  assign wait_over = (frame_cnt == FRAME_LAST) && (move_cnt == MOVE_LAST);

  // State register; reset returns to IDLE on the next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Frame/move timer runs only in WAIT and is held clear elsewhere, so every WAIT entry starts from zero.
  always_ff @(posedge clock) begin
    if (reset || (cur_state != S_WAIT)) begin
      frame_cnt <= '0;
      move_cnt  <= '0;
    end else if (frame_cnt == FRAME_LAST) begin
      frame_cnt <= '0;
      move_cnt  <= move_cnt + 8'd1;
    end else begin
      frame_cnt <= frame_cnt + 20'd1;
    end
  end

  // Output decode and next-state: selects from state, inc/done from the counters against the region size.
  always_comb begin
    nxt_state           = cur_state;
    draw_bg_black       = 1'b0;
    draw_bg_green_left  = 1'b0;
    draw_bg_green_right = 1'b0;
    draw_car            = 1'b0;
    erase               = 1'b0;
    update              = 1'b0;
    plot                = 1'b0;
    w_last              = '0;
    h_last              = '0;

    case (cur_state)
      S_IDLE: begin
        if (start) nxt_state = S_BG_BLACK;
      end
      S_BG_BLACK: begin
        draw_bg_black = 1'b1;
        plot          = 1'b1;
        w_last        = SCREEN_W_LAST;
        h_last        = SCREEN_H_LAST;
      end
      S_BG_LEFT: begin
        draw_bg_green_left = 1'b1;
        plot               = 1'b1;
        w_last             = GRASS_W_LAST;
        h_last             = SCREEN_H_LAST;
      end
      S_BG_RIGHT: begin
        draw_bg_green_right = 1'b1;
        plot                = 1'b1;
        w_last              = GRASS_W_LAST;
        h_last              = SCREEN_H_LAST;
      end
      S_DRAW_CAR: begin
        draw_car = 1'b1;
        plot     = 1'b1;
        w_last   = CAR_W_LAST;
        h_last   = CAR_H_LAST;
      end
      S_WAIT: begin
        if (wait_over) nxt_state = S_ERASE;
      end
      S_ERASE: begin
        erase  = 1'b1;
        plot   = 1'b1;
        w_last = CAR_W_LAST;
        h_last = CAR_H_LAST;
      end
      S_UPDATE: begin
        update    = 1'b1;
        nxt_state = S_DRAW_CAR;
      end
      default: nxt_state = S_IDLE;
    endcase

    // A counter beyond its region never matches the last column/row, so an out-of-sync datapath stalls here.
    inc  = plot & (counterx == w_last);
    done = inc & (countery == h_last);

    if (done) begin
      case (cur_state)
        S_BG_BLACK: nxt_state = S_BG_LEFT;
        S_BG_LEFT:  nxt_state = S_BG_RIGHT;
        S_BG_RIGHT: nxt_state = S_DRAW_CAR;
        S_DRAW_CAR: nxt_state = S_WAIT;
        S_ERASE:    nxt_state = S_UPDATE;
        default:    nxt_state = cur_state;
      endcase
    end
  end

endmodule

// File: tb/tb_car_draw_control.sv
// tb/tb_car_draw_control.sv - randomized self-checking bench with datapath and sequence models
module tb_car_draw_control;

  localparam int SW  = 4;
  localparam int SH  = 3;
  localparam int GW  = 1;
  localparam int CW  = 2;
  localparam int CH  = 2;
  localparam int FC  = 3;
  localparam int FPM = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] counterx;
  logic [7:0] countery;
  logic       draw_bg_black, draw_bg_green_left, draw_bg_green_right;
  logic       draw_car, erase, update, plot, inc, done;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  // datapath model state
  logic       ovr_en    = 1'b0;
  logic [7:0] ovr_x     = 8'd0;
  logic       cx_forced = 1'b0;
  logic       s_plot = 1'b0, s_inc = 1'b0, s_done = 1'b0;

  // reference sequence model: phase code and cycle index within the phase
  int m_phase = 0;
  int m_k     = 0;

  always #5 clock = ~clock;

  car_draw_control #(
    .SCREEN_W(SW), .SCREEN_H(SH), .GRASS_W(GW), .CAR_W(CW), .CAR_H(CH),
    .FRAME_CYCLES(FC), .FRAMES_PER_MOVE(FPM)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .counterx(counterx), .countery(countery),
    .draw_bg_black(draw_bg_black), .draw_bg_green_left(draw_bg_green_left),
    .draw_bg_green_right(draw_bg_green_right), .draw_car(draw_car),
    .erase(erase), .update(update), .plot(plot), .inc(inc), .done(done),
    .state(state)
  );

  function automatic bit is_draw(int ph);
    return (ph == 1) || (ph == 2) || (ph == 3) || (ph == 4) || (ph == 6);
  endfunction

  function automatic int phase_len(int ph);
    case (ph)
      1:       return SW * SH;
      2, 3:    return GW * SH;
      4, 6:    return CW * CH;
      5:       return FC * FPM;
      7:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int phase_w(int ph);
    case (ph)
      1:       return SW;
      2, 3:    return GW;
      4, 6:    return CW;
      default: return 1;
    endcase
  endfunction

  function automatic int phase_next(int ph);
    case (ph)
      1: return 2;
      2: return 3;
      3: return 4;
      4: return 5;
      5: return 6;
      6: return 7;
      7: return 4;
      default: return 0;
    endcase
  endfunction

  // {state[3:0], black, left, right, car, erase, update, plot, inc, done}
  function automatic logic [12:0] exp_vec();
    logic [12:0] v;
    int w;
    v = '0;
    v[12:9] = m_phase[3:0];
    case (m_phase)
      1: v[8] = 1'b1;
      2: v[7] = 1'b1;
      3: v[6] = 1'b1;
      4: v[5] = 1'b1;
      6: v[4] = 1'b1;
      7: v[3] = 1'b1;
      default: ;
    endcase
    if (is_draw(m_phase)) begin
      w = phase_w(m_phase);
      v[2] = 1'b1;
      if (cx_forced) begin
        v[1] = (int'(ovr_x) == w - 1);
        v[0] = 1'b0;
      end else begin
        v[1] = ((m_k % w) == w - 1);
        v[0] = (m_k == phase_len(m_phase) - 1);
      end
    end
    return v;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic forced);
    if (r) begin
      m_phase = 0;
      m_k     = 0;
    end else if (m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_k     = 0;
      end
    end else if (forced && is_draw(m_phase)) begin
      m_k = m_k;
    end else if (m_k == phase_len(m_phase) - 1) begin
      m_phase = phase_next(m_phase);
      m_k     = 0;
    end else begin
      m_k = m_k + 1;
    end
  endtask

  // one clock: datapath counters react to the strobes seen before the edge, then outputs are sampled mid-cycle
  task automatic cycle(output logic [12:0] obs, output logic [12:0] expv);
    logic r, s, fb;
    r  = reset;
    s  = start;
    fb = cx_forced;
    @(posedge clock);
    #1;
    if (r) begin
      counterx  = 8'd0;
      countery  = 8'd0;
      cx_forced = 1'b0;
    end else if (ovr_en) begin
      counterx  = ovr_x;
      cx_forced = 1'b1;
    end else begin
      cx_forced = 1'b0;
      if (s_done) begin
        counterx = 8'd0;
        countery = 8'd0;
      end else if (s_inc) begin
        counterx = 8'd0;
        countery = countery + 8'd1;
      end else if (s_plot) begin
        counterx = counterx + 8'd1;
      end
    end
    model_step(r, s, fb);
    @(negedge clock);
    obs = {state, draw_bg_black, draw_bg_green_left, draw_bg_green_right, draw_car,
           erase, update, plot, inc, done};
    s_plot = plot;
    s_inc  = inc;
    s_done = done;
    expv   = exp_vec();
  endtask

  task automatic test_reset();
    logic [12:0] obs, expv;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) reset = 1'b0;
      cycle(obs, expv);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs, expv);
      end
    end
  endtask

  task automatic test_background();
    logic [12:0] obs, expv;
    int idle_n, hold, n, inc_black, done_black;
    idle_n = $urandom_range(0, 3);
    hold   = $urandom_range(1, 3);
    for (int i = 0; i < idle_n; i++) begin
      cycle(obs, expv);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL bg_idle cyc=%0d got=%b want=%b", i, obs, expv);
      end
    end
    start      = 1'b1;
    n          = 0;
    inc_black  = 0;
    done_black = 0;
    while (n < 200) begin
      if (n == hold) start = 1'b0;
      cycle(obs, expv);
      n++;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL bg_seq cyc=%0d got=%b want=%b", n, obs, expv);
      end
      if (obs[12:9] == 4'd1 && obs[1]) inc_black++;
      if (obs[12:9] == 4'd1 && obs[0]) done_black++;
      if (expv[12:9] == 4'd5) break;
    end
    start = 1'b0;
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL bg_timeout got=%0d want<200", n);
    end
    total++;
    if (inc_black != SH) begin
      bad++;
      $display("FAIL bg_black_inc got=%0d want=%0d", inc_black, SH);
    end
    total++;
    if (done_black != 1) begin
      bad++;
      $display("FAIL bg_black_done got=%0d want=1", done_black);
    end
  endtask

  task automatic test_loop();
    logic [12:0] obs, expv;
    int upd_at[$];
    int iter_len;
    iter_len = 2 * CW * CH + FC * FPM + 1;
    start = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3 * iter_len + 5; i++) begin
      cycle(obs, expv);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL loop_seq cyc=%0d got=%b want=%b", i, obs, expv);
      end
      if (obs[3]) upd_at.push_back(i);
    end
    total++;
    if (upd_at.size() != 3) begin
      bad++;
      $display("FAIL loop_update_count got=%0d want=3", upd_at.size());
    end
    for (int j = 1; j < upd_at.size(); j++) begin
      total++;
      if (upd_at[j] - upd_at[j-1] != 15) begin
        bad++;
        $display("FAIL loop_period got=%0d want=15", upd_at[j] - upd_at[j-1]);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [12:0] obs, expv;
    int n, wk, wait_len;
    bit hit_black, hit_wait;
    reset = 1'b1;
    start = 1'b1;
    cycle(obs, expv);
    reset = 1'b0;
    hit_black = 0;
    hit_wait  = 0;
    wk        = $urandom_range(1, 4);
    wait_len  = 0;
    n         = 0;
    while (n < 300) begin
      cycle(obs, expv);
      n++;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL rst_mid cyc=%0d got=%b want=%b", n, obs, expv);
      end
      if (reset) begin
        reset = 1'b0;
        total++;
        if (obs !== 13'd0) begin
          bad++;
          $display("FAIL rst_mid_zero got=%b want=0", obs);
        end
      end else if (!hit_black && expv[12:9] == 4'd1 && m_k == 4) begin
        hit_black = 1;
        reset     = 1'b1;
      end else if (hit_black && !hit_wait && expv[12:9] == 4'd5 && m_k == wk) begin
        hit_wait = 1;
        reset    = 1'b1;
      end
      if (hit_wait && !reset && obs[12:9] == 4'd5) wait_len++;
      if (hit_wait && !reset && obs[12:9] == 4'd6) break;
    end
    start = 1'b0;
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL rst_mid_timeout got=%0d want<300", n);
    end
    total++;
    if (wait_len != FC * FPM) begin
      bad++;
      $display("FAIL rst_mid_wait_len got=%0d want=%0d", wait_len, FC * FPM);
    end
  endtask

  task automatic test_counter_integrity();
    logic [12:0] obs, expv;
    int n;
    reset = 1'b1;
    start = 1'b1;
    cycle(obs, expv);
    reset = 1'b0;
    n     = 0;
    while (n < 100) begin
      cycle(obs, expv);
      n++;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL integ_reach cyc=%0d got=%b want=%b", n, obs, expv);
      end
      if (expv[12:9] == 4'd4) break;
    end
    start = 1'b0;
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL integ_timeout got=%0d want<100", n);
    end
    ovr_en = 1'b1;
    ovr_x  = 8'd5;
    for (int i = 0; i < 10; i++) begin
      cycle(obs, expv);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL integ_hold cyc=%0d got=%b want=%b", i, obs, expv);
      end
      total++;
      if (i > 0 && (obs[0] !== 1'b0 || obs[12:9] !== 4'd4)) begin
        bad++;
        $display("FAIL integ_no_done cyc=%0d got=state %0d done %b want=state 4 done 0", i, obs[12:9], obs[0]);
      end
    end
    ovr_en = 1'b0;
    reset  = 1'b1;
    cycle(obs, expv);
    total++;
    if (obs !== 13'd0) begin
      bad++;
      $display("FAIL integ_reset got=%b want=0", obs);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    counterx = 8'd0;
    countery = 8'd0;
    test_reset();
    test_background();
    test_loop();
    test_reset_mid();
    test_counter_integrity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
